pipe_muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer for the EXE stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU from ID/EXE and runs a 32-iteration shift-add multiplier or restoring divider.
- Raises the pipeline stall while running, then presents a one-cycle HI/LO write (hi, lo, hi_lo_wena) for the WB path.
- Replaces the single-cycle mul/div units in EXE.

---
 rtl/pipe_muldiv_seq.sv | 176 +++++++++++++++++
 tb/tb_pipe_muldiv_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv_seq.sv
// Multi-cycle multiply/divide sequencer for the EXE stage.
// Runs a WIDTH-iteration shift-add multiplier or restoring divider on operand
// magnitudes, fixes up signs in one extra cycle, then presents a one-cycle
// HI/LO write. The pipeline is stalled from issue until the result is ready.
// ITER must equal WIDTH: one quotient/multiplier bit is consumed per iteration.
module pipe_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_wena,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT            state;
    logic [CW-1:0]    iterCount;
    logic             divOp;       // 1 = divide, 0 = multiply
    logic             resultNeg;   // negate product / quotient at FIX
    logic             remNeg;      // negate remainder at FIX
    logic             divZero;     // divide by zero: bypass the datapath result
    logic [WIDTH-1:0] origA;       // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0] magA;        // multiplicand magnitude (multiply)
    logic [WIDTH-1:0] magB;        // divisor magnitude (divide)
    logic [WIDTH-1:0] accHi;       // product high half / partial remainder
    logic [WIDTH-1:0] accLo;       // multiplier bits / dividend-then-quotient bits

    // Operand magnitudes at issue: signed ops (op[0]) work on absolute values.
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    assign absA = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    assign absB = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply step: add the multiplicand when the current multiplier LSB is set.
    logic [WIDTH-1:0] mulAddend;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gMulMask
            assign mulAddend[gi] = magA[gi] & accLo[0];
        end
    endgenerate

    logic [WIDTH:0] mulSum;
    assign mulSum = {1'b0, accHi} + {1'b0, mulAddend};

    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    // The shifted remainder needs one extra bit; the trial's MSB is its sign.
    logic [WIDTH:0] divShift;
    logic [WIDTH:0] divTrial;
    logic           divFits;
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divTrial = divShift - {1'b0, magB};
    assign divFits  = ~divTrial[WIDTH];

    // Sign fix-up of the unsigned results, modulo 2^WIDTH / 2^(2*WIDTH).
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodSigned;
    logic [WIDTH-1:0]   quotSigned;
    logic [WIDTH-1:0]   remSigned;
    assign product    = {accHi, accLo};
    assign prodSigned = resultNeg ? -product : product;
    assign quotSigned = resultNeg ? -accLo : accLo;
    assign remSigned  = remNeg ? -accHi : accHi;

    // Sequencer: issue, iterate, sign fix-up, result cycle; flush aborts before DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            iterCount <= '0;
            divOp     <= 1'b0;
            resultNeg <= 1'b0;
            remNeg    <= 1'b0;
            divZero   <= 1'b0;
            origA     <= '0;
            magA      <= '0;
            magB      <= '0;
            accHi     <= '0;
            accLo     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        divOp     <= op[1];
                        resultNeg <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        remNeg    <= op[0] & src_a[WIDTH-1];
                        divZero   <= op[1] & (src_b == '0);
                        origA     <= src_a;
                        magA      <= absA;
                        magB      <= absB;
                        accHi     <= '0;
                        // Divide shifts the dividend out of accLo; multiply shifts the multiplier.
                        accLo     <= op[1] ? absA : absB;
                        iterCount <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (divOp) begin
                            accHi <= divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
                            accLo <= {accLo[WIDTH-2:0], divFits};
                        end else begin
                            accHi <= mulSum[WIDTH:1];
                            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                        end
                        iterCount <= iterCount + 1'b1;
                        if (iterCount == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (divZero) begin
                            hi <= origA;
                            lo <= '1;
                        end else if (divOp) begin
                            hi <= remSigned;
                            lo <= quotSigned;
                        end else begin
                            hi <= prodSigned[2*WIDTH-1:WIDTH];
                            lo <= prodSigned[WIDTH-1:0];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs: in IDLE the stall follows start so the issuing instruction holds in EXE.
    always_comb begin
        busy       = (state != IDLE);
        stall      = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                stall = start;
            end else begin
                stall = (state == RUN) || (state == FIX);
            end
        end
        done       = (state == DONE) && !flush;
        hi_lo_wena = done;
    end

endmodule

// File: tb/tb_pipe_muldiv_seq.sv
// Self-checking bench for pipe_muldiv_seq: directed vectors, randomized operations
// against an arithmetic reference model, flush, start-while-busy and reset cases.
module tb_pipe_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic        hi_lo_wena;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared = 0;
    int mismatched = 0;

    // Per-cycle observations of the last operation; index k = sample after edge E_k.
    logic        obsBusy  [0:39];
    logic        obsStall [0:39];
    logic        obsDone  [0:39];
    logic        obsWena  [0:39];
    logic [31:0] obsHi    [0:39];
    logic [31:0] obsLo    [0:39];
    logic        issueStall;
    int          obsDoneAt;
    int          obsDoneCount;
    int          obsWenaCount;
    logic [31:0] doneHi;
    logic [31:0] doneLo;

    pipe_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi_lo_wena (hi_lo_wena),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Reference model: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        case (o)
            2'b00: return {32'h0, a} * {32'h0, b};
            2'b01: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                ma = a[31] ? (32'h0 - a) : a;
                mb = b[31] ? (32'h0 - b) : b;
                q = ma / mb;
                r = ma % mb;
                if (a[31] != b[31]) q = 32'h0 - q;
                if (a[31]) r = 32'h0 - r;
                return {r, q};
            end
        endcase
    endfunction

    // Issues one operation and records nCycles of outputs; flushAt/pulseAt raise
    // flush or a stray start at sample index k (-1 for none).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flushAt, input int pulseAt, input int nCycles);
        @(negedge clk);
        start = 1'b1;
        flush = 1'b0;
        op    = o;
        src_a = a;
        src_b = b;
        #1 issueStall = stall;
        obsDoneAt    = -1;
        obsDoneCount = 0;
        obsWenaCount = 0;
        doneHi       = 'x;
        doneLo       = 'x;
        for (int k = 0; k < nCycles; k++) begin
            @(negedge clk);
            start = (k == pulseAt);
            flush = (k == flushAt);
            if (k == pulseAt) begin
                op    = 2'($urandom_range(0, 3));
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            obsBusy[k]  = busy;
            obsStall[k] = stall;
            obsDone[k]  = done;
            obsWena[k]  = hi_lo_wena;
            obsHi[k]    = hi;
            obsLo[k]    = lo;
            if (hi_lo_wena === 1'b1) obsWenaCount++;
            if (done === 1'b1) begin
                obsDoneCount++;
                if (obsDoneAt < 0) begin
                    obsDoneAt = k;
                    doneHi = hi;
                    doneLo = lo;
                end
            end
        end
        start = 1'b0;
        flush = 1'b0;
        $display("op=%0d a=%h b=%h -> done@%0d hi=%h lo=%h (flushAt=%0d pulseAt=%0d)",
                 o, a, b, obsDoneAt, doneHi, doneLo, flushAt, pulseAt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b expected 0", stall); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        compared++; if (hi_lo_wena !== 1'b0) begin mismatched++; $display("FAIL reset_wena: got %b expected 0", hi_lo_wena); end
        compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL reset_hi: got %h expected 0", hi); end
        compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_multu_timing();
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, 36);
        compared++; if (issueStall !== 1'b1) begin mismatched++; $display("FAIL issue_stall: got %b expected 1", issueStall); end
        for (int k = 0; k < 36; k++) begin
            compared++; if (obsBusy[k] !== (k <= 33)) begin mismatched++; $display("FAIL busy[%0d]: got %b expected %b", k, obsBusy[k], (k <= 33)); end
            compared++; if (obsStall[k] !== (k <= 32)) begin mismatched++; $display("FAIL stall[%0d]: got %b expected %b", k, obsStall[k], (k <= 32)); end
            compared++; if (obsDone[k] !== (k == 33)) begin mismatched++; $display("FAIL done[%0d]: got %b expected %b", k, obsDone[k], (k == 33)); end
            compared++; if (obsWena[k] !== (k == 33)) begin mismatched++; $display("FAIL wena[%0d]: got %b expected %b", k, obsWena[k], (k == 33)); end
        end
        compared++; if (obsHi[32] !== 32'h0) begin mismatched++; $display("FAIL hi_before_fix: got %h expected 0", obsHi[32]); end
        compared++; if (obsHi[33] !== 32'hFFFFFFFE) begin mismatched++; $display("FAIL multu_hi: got %h expected fffffffe", obsHi[33]); end
        compared++; if (obsLo[33] !== 32'h00000001) begin mismatched++; $display("FAIL multu_lo: got %h expected 00000001", obsLo[33]); end
    endtask

    task automatic test_directed();
        logic [1:0]  vOp [8] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
        logic [31:0] vA  [8] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100,
                                 32'd7, 32'h00001234, 32'h80000000, 32'hFFFFFF00};
        logic [31:0] vB  [8] = '{32'd7, 32'h80000000, 32'd2, 32'd7,
                                 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] vHi [8] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h2,
                                 32'h1, 32'h1234, 32'h0, 32'hFFFFFF00};
        logic [31:0] vLo [8] = '{32'hFFFFFFEB, 32'h0, 32'hFFFFFFFD, 32'hE,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 8; i++) begin
            run_op(vOp[i], vA[i], vB[i], -1, -1, 35);
            compared++; if (obsDoneAt !== 33) begin mismatched++; $display("FAIL dir%0d_latency: got %0d expected 33", i, obsDoneAt); end
            compared++; if (doneHi !== vHi[i]) begin mismatched++; $display("FAIL dir%0d_hi: got %h expected %h", i, doneHi, vHi[i]); end
            compared++; if (doneLo !== vLo[i]) begin mismatched++; $display("FAIL dir%0d_lo: got %h expected %h", i, doneLo, vLo[i]); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] keepHi;
        logic [31:0] keepLo;
        logic [63:0] expv;
        // Completed MULTU establishes a known HI/LO.
        run_op(2'b00, 32'h12345678, 32'h9ABCDEF1, -1, -1, 35);
        expv = ref_result(2'b00, 32'h12345678, 32'h9ABCDEF1);
        keepHi = expv[63:32];
        keepLo = expv[31:0];
        compared++; if (doneHi !== keepHi || doneLo !== keepLo) begin mismatched++; $display("FAIL flush_pre: got %h_%h expected %h_%h", doneHi, doneLo, keepHi, keepLo); end
        // DIVU flushed at iteration 10.
        run_op(2'b10, 32'hDEADBEEF, 32'd13, 9, -1, 36);
        compared++; if (obsBusy[9] !== 1'b1) begin mismatched++; $display("FAIL flush_busy_before: got %b expected 1", obsBusy[9]); end
        compared++; if (obsBusy[10] !== 1'b0) begin mismatched++; $display("FAIL flush_busy_after: got %b expected 0", obsBusy[10]); end
        compared++; if (obsStall[10] !== 1'b0) begin mismatched++; $display("FAIL flush_stall_after: got %b expected 0", obsStall[10]); end
        compared++; if (obsWenaCount !== 0) begin mismatched++; $display("FAIL flush_wena: got %0d pulses expected 0", obsWenaCount); end
        compared++; if (obsHi[35] !== keepHi || obsLo[35] !== keepLo) begin mismatched++; $display("FAIL flush_hold: got %h_%h expected %h_%h", obsHi[35], obsLo[35], keepHi, keepLo); end
        // Flush during FIX: no result, HI/LO unchanged.
        run_op(2'b01, 32'hFFFFFFF0, 32'd5, 32, -1, 36);
        compared++; if (obsDoneCount !== 0) begin mismatched++; $display("FAIL flush_fix_done: got %0d pulses expected 0", obsDoneCount); end
        compared++; if (obsBusy[33] !== 1'b0) begin mismatched++; $display("FAIL flush_fix_busy: got %b expected 0", obsBusy[33]); end
        compared++; if (obsHi[35] !== keepHi || obsLo[35] !== keepLo) begin mismatched++; $display("FAIL flush_fix_hold: got %h_%h expected %h_%h", obsHi[35], obsLo[35], keepHi, keepLo); end
        // Flush during DONE suppresses the pulse; the FIX write already happened.
        run_op(2'b10, 32'd1000, 32'd33, 33, -1, 36);
        compared++; if (obsDone[33] !== 1'b0 || obsWena[33] !== 1'b0) begin mismatched++; $display("FAIL flush_done_pulse: got done=%b wena=%b expected 0 0", obsDone[33], obsWena[33]); end
        compared++; if (obsHi[33] !== 32'd10 || obsLo[33] !== 32'd30) begin mismatched++; $display("FAIL flush_done_result: got %h_%h expected 0000000a_0000001e", obsHi[33], obsLo[33]); end
        compared++; if (obsBusy[34] !== 1'b0) begin mismatched++; $display("FAIL flush_done_busy: got %b expected 0", obsBusy[34]); end
        // A new start after the flush completes normally.
        run_op(2'b11, 32'hFFFFFF9C, 32'd7, -1, -1, 35);
        compared++; if (obsDoneAt !== 33) begin mismatched++; $display("FAIL flush_restart_latency: got %0d expected 33", obsDoneAt); end
        compared++; if (doneHi !== 32'hFFFFFFFE || doneLo !== 32'hFFFFFFF2) begin mismatched++; $display("FAIL flush_restart_result: got %h_%h expected fffffffe_fffffff2", doneHi, doneLo); end
        // Start together with flush in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL idle_flush_stall: got %b expected 1", stall); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_flush_accept: got busy=%b expected 0", busy); end
        $display("start with flush in IDLE: busy=%b", busy);
    endtask

    task automatic test_start_during_run();
        logic [63:0] expv;
        run_op(2'b00, 32'h0000FFFF, 32'h00010001, -1, 15, 36);
        expv = ref_result(2'b00, 32'h0000FFFF, 32'h00010001);
        compared++; if (obsDoneCount !== 1) begin mismatched++; $display("FAIL run_start_count: got %0d pulses expected 1", obsDoneCount); end
        compared++; if (doneHi !== expv[63:32] || doneLo !== expv[31:0]) begin mismatched++; $display("FAIL run_start_result: got %h_%h expected %h", doneHi, doneLo, expv); end
        compared++; if (obsBusy[34] !== 1'b0 || obsBusy[35] !== 1'b0) begin mismatched++; $display("FAIL run_start_requeue: got busy %b %b expected 0 0", obsBusy[34], obsBusy[35]); end
        // Start raised in DONE is not accepted either.
        run_op(2'b10, 32'd77, 32'd9, -1, 33, 36);
        compared++; if (obsDoneCount !== 1 || obsDoneAt !== 33) begin mismatched++; $display("FAIL done_start_count: got %0d@%0d expected 1@33", obsDoneCount, obsDoneAt); end
        compared++; if (obsBusy[34] !== 1'b0 || obsBusy[35] !== 1'b0) begin mismatched++; $display("FAIL done_start_accept: got busy %b %b expected 0 0", obsBusy[34], obsBusy[35]); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1;
        logic [63:0] e2;
        e1 = ref_result(2'b01, 32'hFFFF0000, 32'h00012345);
        e2 = ref_result(2'b11, 32'h7FFFFFFF, 32'hFFFFFFF3);
        run_op(2'b01, 32'hFFFF0000, 32'h00012345, -1, -1, 34);
        compared++; if (doneHi !== e1[63:32] || doneLo !== e1[31:0] || obsDoneAt !== 33) begin mismatched++; $display("FAIL b2b_first: got %h_%h@%0d expected %h@33", doneHi, doneLo, obsDoneAt, e1); end
        run_op(2'b11, 32'h7FFFFFFF, 32'hFFFFFFF3, -1, -1, 34);
        compared++; if (issueStall !== 1'b1) begin mismatched++; $display("FAIL b2b_issue_stall: got %b expected 1", issueStall); end
        compared++; if (doneHi !== e2[63:32] || doneLo !== e2[31:0] || obsDoneAt !== 33) begin mismatched++; $display("FAIL b2b_second: got %h_%h@%0d expected %h@33", doneHi, doneLo, obsDoneAt, e2); end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expv;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h80000000;
                2: b = $urandom_range(1, 15);
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            expv = ref_result(o, a, b);
            run_op(o, a, b, -1, -1, 35);
            compared++; if (obsDoneAt !== 33 || obsDoneCount !== 1) begin mismatched++; $display("FAIL rnd%0d_timing: got %0d pulses at %0d expected 1 at 33", i, obsDoneCount, obsDoneAt); end
            compared++; if (obsWenaCount !== obsDoneCount) begin mismatched++; $display("FAIL rnd%0d_wena: got %0d expected %0d", i, obsWenaCount, obsDoneCount); end
            compared++; if (doneHi !== expv[63:32]) begin mismatched++; $display("FAIL rnd%0d_hi: op=%0d a=%h b=%h got %h expected %h", i, o, a, b, doneHi, expv[63:32]); end
            compared++; if (doneLo !== expv[31:0]) begin mismatched++; $display("FAIL rnd%0d_lo: op=%0d a=%h b=%h got %h expected %h", i, o, a, b, doneLo, expv[31:0]); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'hFFFFFFF1; src_b = 32'h0000ABCD;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL areset_busy: got %b expected 0", busy); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL areset_stall: got %b expected 0", stall); end
        compared++; if (done !== 1'b0 || hi_lo_wena !== 1'b0) begin mismatched++; $display("FAIL areset_done: got %b %b expected 0 0", done, hi_lo_wena); end
        compared++; if (hi !== 32'h0 || lo !== 32'h0) begin mismatched++; $display("FAIL areset_hilo: got %h_%h expected 0_0", hi, lo); end
        $display("async reset mid-run: busy=%b stall=%b hi=%h lo=%h", busy, stall, hi, lo);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(2'b10, 32'hFFFFFFFF, 32'h00010000, -1, -1, 35);
        compared++; if (doneHi !== 32'h0000FFFF || doneLo !== 32'h0000FFFF || obsDoneAt !== 33) begin mismatched++; $display("FAIL areset_after: got %h_%h@%0d expected 0000ffff_0000ffff@33", doneHi, doneLo, obsDoneAt); end
    endtask

    initial begin
        test_reset();
        test_multu_timing();
        test_directed();
        test_flush();
        test_start_during_run();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
